map_port_arb: RTL and testbench
===============================

Name: map_port_arb

Overview:
- Round-robin arbiter that shares one clk-domain map read port among NUM_REQ lookup requesters: P1 tank check, P2 tank check and bullet wall check.
- Replaces the per-requester map copies in the game controller with a single map instance plus this block.
- Provides a per-requester req/ack handshake and a tagged, fixed-latency response.
- The renderer keeps its own pclk map port and is out of scope.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = P1, 1 = P2, 2 = bullet.
- MAP_LAT, 1, cycles from map_rd_x/y being driven to map_rd_wall being valid; range 1..4.
- MAP_W, 200, map width in cells; x >= MAP_W is out of bounds.
- MAP_H, 150, map height in cells; y >= MAP_H is out of bounds.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester lookup request, level
- req_x  in  NUM_REQ*8  packed x coordinates, slice i belongs to requester i
- req_y  in  NUM_REQ*8  packed y coordinates
- ack  out  NUM_REQ  one-hot one-cycle pulse: request accepted
- rsp_valid  out  NUM_REQ  one-hot one-cycle pulse: response for requester i
- rsp_wall  out  1  wall result, qualified by rsp_valid
- map_rd_x  out  8  to shared map read port
- map_rd_y  out  8  to shared map read port
- map_rd_wall  in  1  from shared map, valid MAP_LAT cycles after address

Behaviour:
- Reset is synchronous active-low on rstn, clock clk. Reset values:
  - ack = 0, rsp_valid = 0, rsp_wall = 0
  - map_rd_x = 0, map_rd_y = 0
  - rr_ptr = 0; tag pipeline cleared (all valid bits 0)
- Reset mid-flight discards all in-flight lookups; no rsp_valid is emitted for them.
- Arbitration, one grant per cycle:
  - Search req starting at rr_ptr, wrapping modulo NUM_REQ; first asserted index g wins.
  - Register outputs: ack[g] = 1, map_rd_x/y = req_x/y slice g, tag stage 0 = {valid = 1, id = g, oob}.
  - oob = (x >= MAP_W) or (y >= MAP_H), using an 8-bit unsigned compare.
  - rr_ptr <= (g + 1) mod NUM_REQ.
  - No request: ack = 0, stage 0 valid = 0, map_rd_x/y hold their last value, rr_ptr unchanged.
- Handshake rules:
  - A requester holds req and its coordinates stable until it sees ack.
  - To issue a back-to-back lookup, the requester keeps req high in the cycle ack is seen.
  - Deasserting req before ack withdraws the request silently.
  - req sampled in the ack cycle counts as a new request, eligible after rotation.
- Fairness: every requester that holds req is acked within NUM_REQ cycles. Throughput is one lookup per cycle when busy.
- Tag pipeline: MAP_LAT stages, {valid, id[clog2(NUM_REQ)-1:0], oob}, shifted every cycle.
- Response timing: total latency from ack to rsp_valid is exactly MAP_LAT cycles.
  - Output stage valid: rsp_valid[id] = 1 and rsp_wall = oob | map_rd_wall, both registered.
  - Otherwise rsp_valid = 0 and rsp_wall holds its last value.
- Out-of-bounds: the map is still addressed with the raw coordinates, and the response is forced to wall = 1 with unchanged latency.
- Simultaneous events:
  - An ack to one requester and an rsp_valid to a different requester in the same cycle are legal.
  - The same requester may see ack and rsp_valid for its previous lookup in the same cycle.
- Invariants:
  - ack is one-hot or zero.
  - rsp_valid is one-hot or zero.
  - Responses to a requester arrive in issue order.

Decomposition:
- Shared package game_pkg:
  - MAP_W, MAP_H constants
  - REQ_P1 = 0, REQ_P2 = 1, REQ_BULLET = 2
  - tag typedef {valid, id, oob}
- One natural sub-module, rr_pick: combinational round-robin priority picker (req vector, ptr) -> (any, grant index). It is reused later for bullet-slot allocation.

Test Plan:
- Single request: MAP_LAT = 1, req = 3'b001, coords (10,70), map returns 1 → ack[0] at cycle 1, map_rd = (10,70), rsp_valid = 3'b001 with rsp_wall = 1 at cycle 2.
- Contention: req = 3'b111 held, rr_ptr = 0 → acks 0, 1, 2, 0, 1, 2 on consecutive cycles; rsp_valid follows the same order shifted by MAP_LAT.
- Withdraw: req[1] pulses for one cycle while req[0] is granted → no ack[1], no rsp_valid[1]; rr_ptr moves to 1, then the next grant goes to 2 if requested.
- Out of bounds: requester 2 asks for (200,10), map returns 0 → rsp_valid[2] with rsp_wall = 1. A request for (199,149) returns the map value unmodified.
- Latency: MAP_LAT = 3, stream of 6 alternating P1/P2 lookups → each rsp_valid exactly 3 cycles after its ack, correct id and order, no bubbles.
- Reset mid-flight: rstn low for 1 cycle with 2 lookups in flight → no rsp_valid afterwards; all outputs 0; the next grant goes to requester 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-controller definitions: map geometry, requester ids and the
// lookup tag carried alongside the shared map read.
package game_pkg;

   localparam int unsigned MAP_W = 200;
   localparam int unsigned MAP_H = 150;
   localparam int unsigned ID_W  = 2;

   typedef enum logic [ID_W-1:0] {
      REQ_P1     = 2'd0,
      REQ_P2     = 2'd1,
      REQ_BULLET = 2'd2
   } req_id_e;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            oob;
   } map_tag_t;

   // Zero-extended unsigned compare; identical to an 8-bit compare for any map
   // that fits in 8-bit coordinates.
   function automatic logic coord_oob(input logic [7:0] x, input logic [7:0] y,
                                      input int unsigned w, input int unsigned h);
      return (32'(x) >= w) || (32'(y) >= h);
   endfunction

endpackage

// File: rtl/map_port_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick #(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [IW-1:0] o_grant
);

   int unsigned w_idx;

   always_comb begin
      o_any   = 1'b0;
      o_grant = '0;
      w_idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         w_idx = (32'(i_ptr) + i) % N;
         if (!o_any && i_req[w_idx]) begin
            o_any   = 1'b1;
            o_grant = IW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/map_port_arb.sv
// Round-robin sharing of the single clk-domain map read port between the
// tank and bullet wall checks, with a tagged fixed-latency response.
module map_port_arb #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned MAP_LAT = 1,
   parameter int unsigned MAP_W   = game_pkg::MAP_W,
   parameter int unsigned MAP_H   = game_pkg::MAP_H
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_x,
   input  logic [NUM_REQ*8-1:0] req_y,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic                 rsp_wall,
   output logic [7:0]           map_rd_x,
   output logic [7:0]           map_rd_y,
   input  logic                 map_rd_wall
);

   import game_pkg::*;

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic            w_any;
   logic [IW-1:0]   w_gnt;
   logic [IW-1:0]   w_nxt_ptr;
   logic [7:0]      w_x [NUM_REQ];
   logic [7:0]      w_y [NUM_REQ];
   logic [7:0]      w_gx;
   logic [7:0]      w_gy;
   logic            w_oob;
   map_tag_t        w_out_tag;

   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic               r_rsp_wall;
   logic [7:0]         r_rd_x;
   logic [7:0]         r_rd_y;
   logic [IW-1:0]      r_ptr;
   map_tag_t           r_tag [MAP_LAT];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_x[gi] = req_x[gi*8 +: 8];
      assign w_y[gi] = req_y[gi*8 +: 8];
   end

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_grant (w_gnt)
   );

   assign w_gx      = w_x[w_gnt];
   assign w_gy      = w_y[w_gnt];
   assign w_oob     = coord_oob(w_gx, w_gy, MAP_W, MAP_H);
   assign w_nxt_ptr = (32'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
   assign w_out_tag = r_tag[MAP_LAT-1];

   // Stage 0 is loaded on the grant edge and the response register samples the
   // last stage, so ack-to-rsp_valid is exactly MAP_LAT cycles.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ack       <= '0;
         r_rsp_valid <= '0;
         r_rsp_wall  <= 1'b0;
         r_rd_x      <= '0;
         r_rd_y      <= '0;
         r_ptr       <= '0;
         for (int unsigned i = 0; i < MAP_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_ack    <= '0;
         r_tag[0] <= '0;
         if (w_any) begin
            r_ack[w_gnt] <= 1'b1;
            r_rd_x       <= w_gx;
            r_rd_y       <= w_gy;
            r_tag[0]     <= '{valid: 1'b1, id: ID_W'(w_gnt), oob: w_oob};
            r_ptr        <= w_nxt_ptr;
         end
         for (int unsigned i = 1; i < MAP_LAT; i++) r_tag[i] <= r_tag[i-1];
         r_rsp_valid <= '0;
         if (w_out_tag.valid) begin
            r_rsp_valid[w_out_tag.id] <= 1'b1;
            r_rsp_wall                <= w_out_tag.oob | map_rd_wall;
         end
      end
   end

   assign ack       = r_ack;
   assign rsp_valid = r_rsp_valid;
   assign rsp_wall  = r_rsp_wall;
   assign map_rd_x  = r_rd_x;
   assign map_rd_y  = r_rd_y;

endmodule

// File: tb/tb_map_port_arb.sv
// Bench for map_port_arb: identical stimulus into a MAP_LAT=1 and a MAP_LAT=3
// instance, each with its own map model and response scoreboard.
module tb_map_port_arb;

   typedef struct packed {
      logic [2:0]  req;
      logic [23:0] xs;
      logic [23:0] ys;
      logic [2:0]  ack;
   } vec_t;

   typedef struct packed {
      int unsigned due;
      logic [1:0]  id;
      logic        wall;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [2:0]  req = '0;
   logic [23:0] req_x = '0;
   logic [23:0] req_y = '0;

   logic [2:0] ack1, ack3, rv1, rv3;
   logic       rw1, rw3, mw1, mw3;
   logic [7:0] rx1, ry1, rx3, ry3;
   logic       d1 = 1'b0;
   logic       d2 = 1'b0;

   rsp_t        q1[$];
   rsp_t        q3[$];
   vec_t        vecs[$];
   int unsigned cycle = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   logic        ew1 = 1'b0;
   logic        ew3 = 1'b0;
   logic [7:0]  lx = '0;
   logic [7:0]  ly = '0;

   always #5 clk = ~clk;

   function automatic logic mapfn(input logic [7:0] x, input logic [7:0] y);
      return x[0] ^ y[2];
   endfunction

   function automatic logic exp_wall(input logic [7:0] x, input logic [7:0] y);
      return (x >= 8'd200 || y >= 8'd150) ? 1'b1 : mapfn(x, y);
   endfunction

   function automatic logic [1:0] oh2i(input logic [2:0] a);
      return a[2] ? 2'd2 : (a[1] ? 2'd1 : 2'd0);
   endfunction

   function automatic vec_t mk(input logic [2:0] r,
                               input logic [7:0] x0, input logic [7:0] y0,
                               input logic [7:0] x1, input logic [7:0] y1,
                               input logic [7:0] x2, input logic [7:0] y2,
                               input logic [2:0] a);
      vec_t v;
      v.req = r;
      v.xs  = {x2, x1, x0};
      v.ys  = {y2, y1, y0};
      v.ack = a;
      return v;
   endfunction

   // Map port models: combinational for latency 1, two extra flops for 3.
   assign mw1 = mapfn(rx1, ry1);
   always @(posedge clk) begin
      d1 <= mapfn(rx3, ry3);
      d2 <= d1;
   end
   assign mw3 = d2;

   map_port_arb #(.NUM_REQ(3), .MAP_LAT(1), .MAP_W(200), .MAP_H(150)) u1 (
      .clk(clk), .rstn(rstn), .req(req), .req_x(req_x), .req_y(req_y),
      .ack(ack1), .rsp_valid(rv1), .rsp_wall(rw1),
      .map_rd_x(rx1), .map_rd_y(ry1), .map_rd_wall(mw1)
   );

   map_port_arb #(.NUM_REQ(3), .MAP_LAT(3), .MAP_W(200), .MAP_H(150)) u3 (
      .clk(clk), .rstn(rstn), .req(req), .req_x(req_x), .req_y(req_y),
      .ack(ack3), .rsp_valid(rv3), .rsp_wall(rw3),
      .map_rd_x(rx3), .map_rd_y(ry3), .map_rd_wall(mw3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
      end
   endtask

   task automatic sb_one(input string tag, input logic [2:0] rv, input logic rw,
                         input bit has, input rsp_t head, output bit pop, inout logic ew);
      pop = 1'b0;
      if (has && head.due == cycle) begin
         chk({tag, ".rsp_valid"}, 32'(rv), 32'(3'b001 << head.id));
         ew  = head.wall;
         pop = 1'b1;
      end else begin
         chk({tag, ".rsp_valid"}, 32'(rv), 32'd0);
      end
      chk({tag, ".rsp_wall"}, 32'(rw), 32'(ew));
   endtask

   task automatic step();
      bit   p;
      rsp_t h;
      @(posedge clk);
      #1;
      cycle++;
      h = (q1.size() > 0) ? q1[0] : '0;
      sb_one("L1", rv1, rw1, q1.size() > 0, h, p, ew1);
      if (p) void'(q1.pop_front());
      h = (q3.size() > 0) ? q3[0] : '0;
      sb_one("L3", rv3, rw3, q3.size() > 0, h, p, ew3);
      if (p) void'(q3.pop_front());
   endtask

   task automatic apply(input vec_t v);
      logic [1:0] g;
      logic [7:0] x, y;
      logic       w;
      req   = v.req;
      req_x = v.xs;
      req_y = v.ys;
      if (v.ack != 3'b000) begin
         g  = oh2i(v.ack);
         x  = v.xs[g*8 +: 8];
         y  = v.ys[g*8 +: 8];
         w  = exp_wall(x, y);
         lx = x;
         ly = y;
         q1.push_back('{due: cycle + 2, id: g, wall: w});
         q3.push_back('{due: cycle + 4, id: g, wall: w});
      end
      step();
      chk("L1.ack", 32'(ack1), 32'(v.ack));
      chk("L3.ack", 32'(ack3), 32'(v.ack));
      chk("L1.map_rd", 32'({rx1, ry1}), 32'({lx, ly}));
      chk("L3.map_rd", 32'({rx3, ry3}), 32'({lx, ly}));
   endtask

   task automatic chk_zero(input string tag, input logic [2:0] a, input logic [7:0] x,
                           input logic [7:0] y, input logic [2:0] rv, input logic rw);
      chk({tag, ".rst_ack"}, 32'(a), 32'd0);
      chk({tag, ".rst_rd"}, 32'({x, y}), 32'd0);
      chk({tag, ".rst_rsp"}, 32'({rv, rw}), 32'd0);
   endtask

   initial begin
      // single request, then an out-of-bounds bullet lookup (rr_ptr ends at 0)
      vecs.push_back(mk(3'b001,  10,  70,   0,   0,   0,   0, 3'b001));
      vecs.push_back(mk(3'b000,  10,  70,   0,   0,   0,   0, 3'b000));
      vecs.push_back(mk(3'b000,  10,  70,   0,   0,   0,   0, 3'b000));
      vecs.push_back(mk(3'b100,   0,   0,   0,   0, 200,  10, 3'b100));
      // full contention from rr_ptr = 0
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(3'b111, 1, 2, 3, 4, 5, 6, 3'b001 << (i % 3)));
      end
      // req[1] withdrawn while req[0] is granted
      vecs.push_back(mk(3'b011,  20,  30,  40,  50,   0,   0, 3'b001));
      vecs.push_back(mk(3'b100,   0,   0,   0,   0,  60,  68, 3'b100));
      // boundaries and wrap-around search
      vecs.push_back(mk(3'b100,   0,   0,   0,   0, 199, 149, 3'b100));
      vecs.push_back(mk(3'b010,   0,   0,   5, 150,   0,   0, 3'b010));
      vecs.push_back(mk(3'b001, 255,   0,   0,   0,   0,   0, 3'b001));
      vecs.push_back(mk(3'b101,   8,   0,   0,   0,   0,   4, 3'b100));
      vecs.push_back(mk(3'b001,   8,   0,   0,   0,   0,   4, 3'b001));
      // alternating P1/P2 stream (rr_ptr = 1 here)
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(3'b011, 12, 4, 13, 4, 0, 0, (i % 2 == 0) ? 3'b010 : 3'b001));
      end
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
      end

      rstn = 1'b0;
      step();
      step();
      chk_zero("L1", ack1, rx1, ry1, rv1, rw1);
      chk_zero("L3", ack3, rx3, ry3, rv3, rw3);
      rstn = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // reset with lookups in flight: they are discarded and rr_ptr returns to 0
      apply(mk(3'b011, 12, 4, 13, 4, 0, 0, 3'b010));
      apply(mk(3'b011, 12, 4, 13, 4, 0, 0, 3'b001));
      q1.delete();
      q3.delete();
      ew1  = 1'b0;
      ew3  = 1'b0;
      lx   = '0;
      ly   = '0;
      req  = '0;
      rstn = 1'b0;
      step();
      chk_zero("L1", ack1, rx1, ry1, rv1, rw1);
      chk_zero("L3", ack3, rx3, ry3, rv3, rw3);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) step();
      apply(mk(3'b111, 9, 4, 3, 4, 5, 6, 3'b001));
      for (int i = 0; i < 5; i++) apply(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000));

      chk("L1.queue_drained", 32'(q1.size()), 32'd0);
      chk("L3.queue_drained", 32'(q3.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
